divider: RTL
============

DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have no parameters; the data width SHALL be fixed at 32 bits.
REQ-002 clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 signed_div  input  1  1 = two's-complement division, 0 = unsigned division; sampled with start.
REQ-005 operand_a  input  32  dividend; sampled when start is accepted.
REQ-006 operand_b  input  32  divisor; sampled when start is accepted.
REQ-007 start  input  1  request from the EX stage; SHALL be held high until ready is seen.
REQ-008 annul  input  1  cancels an in-flight division; used on branch or exception flush.
REQ-009 result  output  64  [63:32] remainder (HI), [31:0] quotient (LO); registered.
REQ-010 ready  output  1  result valid; registered.
REQ-011 stall_request  output  1  combinational, = start & ~ready; drives the pipeline control EX stall request.

Function
REQ-012 The states SHALL be FREE, BY_ZERO, ON and END, held in a 2-bit state register.
REQ-013 FREE, start=1, annul=0, operand_b=0: the next edge SHALL enter BY_ZERO.
REQ-014 FREE, start=1, annul=0, operand_b!=0: the next edge (E0) SHALL enter ON and perform the following.
- Clear the 6-bit iteration counter.
- Latch |operand_a| and |operand_b| when signed_div=1, otherwise the raw operands.
- Latch the quotient sign (sign_a XOR sign_b) and the remainder sign (sign_a).
REQ-015 FREE with start=0 or annul=1 SHALL remain in FREE with result=0 and ready=0.
REQ-016 ON, counter<32: each edge SHALL perform one restoring step and then increment the counter.
- Shift {partial remainder, dividend} left by one bit.
- Subtract the divisor from the upper 33 bits.
- If the difference is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
- Steps SHALL occur on E1..E32.
REQ-017 ON, counter=32: edge E33 SHALL perform the following.
- Negate the quotient if the quotient sign is set (signed mode only).
- Negate the remainder if the remainder sign is set (signed mode only).
- Write result, set ready=1, enter END.
- ready SHALL first be high in the cycle after E33, i.e. 34 edges after the start edge.
REQ-018 BY_ZERO: the next edge SHALL write result=0, set ready=1 and enter END (ready high 2 edges after the start edge).
REQ-019 END, start=1: the block SHALL hold result and ready.
REQ-020 END, start=0: the next edge SHALL enter FREE and clear result and ready.
REQ-021 ON or BY_ZERO with annul=1 or start=0: the next edge SHALL enter FREE, clear ready and result, and discard the partial result.
REQ-022 annul SHALL take priority over start in every state except END, where it SHALL be ignored.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL wrap to quotient=0x80000000, remainder=0 with no trap.
REQ-024 Magnitude arithmetic SHALL be unsigned 32-bit; |0x80000000| SHALL be 0x80000000 interpreted as unsigned.
REQ-025 Operand changes after acceptance SHALL NOT affect the in-flight result.
REQ-026 A new start SHALL be accepted only from FREE, at the earliest one edge after leaving END.

Reset
REQ-027 When reset=1 at an edge, the block SHALL enter FREE and clear the following, regardless of state or other inputs:
- result=0, ready=0, counter=0;
- all latched operands and sign flags.
REQ-028 Reset asserted mid-division SHALL abort the division, and no ready pulse SHALL follow.

Verification
REQ-029 Unsigned 100/7, start held: ready=1 exactly 34 edges after acceptance; result={0x00000002, 0x0000000E}; stall_request=1 until then.
REQ-030 Signed -7/2 (0xFFFFFFF9/0x00000002): quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-031 Signed 0x80000000/0xFFFFFFFF: quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF/1: quotient=0xFFFFFFFF, remainder=0.
REQ-032 Any dividend / 0: ready=1 two edges after acceptance; result=0; start low then returns to FREE with ready=0.
REQ-033 annul=1 at iteration 10: FREE next edge, ready stays 0; a following start of 9/3 yields {0, 3} in 34 edges.
REQ-034 reset=1 at iteration 20: FREE, result=0, ready=0; no ready while start remains high until re-accepted from FREE.

Source files
------------

// File: rtl/divider.sv
// Iterative 32-bit restoring divider for the EX stage.
// One restoring step per clock; a request is held on start until ready is seen.
//
// Ports:
//   clock         - single clock, all state updates on the rising edge
//   reset         - synchronous, active-high reset
//   signed_div    - 1: two's-complement division, 0: unsigned; sampled with start
//   operand_a     - 32-bit dividend, sampled when start is accepted
//   operand_b     - 32-bit divisor, sampled when start is accepted
//   start         - division request, held high until ready
//   annul         - cancels an in-flight division (flush)
//   result        - registered {remainder, quotient}
//   ready         - registered result-valid flag
//   stall_request - combinational start & ~ready, EX stall request
module divider (
  input  logic        clock,
  input  logic        reset,
  input  logic        signed_div,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        start,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall_request
);

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;   // dividend bits shift out as quotient bits shift in
  logic [31:0] div_q, div_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] abs_a, abs_b;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic [31:0] fin_quo, fin_rem;

  // Magnitudes are unsigned 32-bit, so |0x80000000| stays 0x80000000.
  assign abs_a = (signed_div && operand_a[31]) ? (~operand_a + 32'd1) : operand_a;
  assign abs_b = (signed_div && operand_b[31]) ? (~operand_b + 32'd1) : operand_b;

  assign shifted = {rem_q, quo_q[31]};
  assign diff    = {1'b0, shifted} - {2'b00, div_q};

  assign fin_quo = neg_q_q ? (~quo_q + 32'd1) : quo_q;
  assign fin_rem = neg_r_q ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;
    ready_d  = ready_q;

    unique case (state_q)
      StFree: begin
        result_d = 64'd0;
        ready_d  = 1'b0;
        if (start && !annul) begin
          if (operand_b == 32'd0) begin
            state_d = StByZero;
          end else begin
            state_d = StOn;
            cnt_d   = 6'd0;
            rem_d   = 32'd0;
            quo_d   = abs_a;
            div_d   = abs_b;
            neg_q_d = signed_div & (operand_a[31] ^ operand_b[31]);
            neg_r_d = signed_div & operand_a[31];
          end
        end
      end

      StByZero: begin
        if (annul || !start) begin
          state_d  = StFree;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end else begin
          state_d  = StEnd;
          result_d = 64'd0;
          ready_d  = 1'b1;
        end
      end

      StOn: begin
        if (annul || !start) begin
          state_d  = StFree;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end else if (cnt_q != 6'd32) begin
          // diff[33] set means the trial subtraction went negative: restore.
          if (!diff[33]) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = shifted[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d  = StEnd;
          result_d = {fin_rem, fin_quo};
          ready_d  = 1'b1;
        end
      end

      StEnd: begin
        // annul is ignored here: the result has already been produced.
        if (!start) begin
          state_d  = StFree;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end
      end

      default: begin
        state_d  = StFree;
        result_d = 64'd0;
        ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StFree;
      cnt_q    <= 6'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      div_q    <= 32'd0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result        = result_q;
  assign ready         = ready_q;
  assign stall_request = start & ~ready_q;

endmodule
